// File: rtl/lf32_add_arbiter.sv
// Round-robin front end that time-shares one Ladner-Fischer 32-bit adder among
// NREQ requesters through a two-register (operand, result) pipeline.

module lf32 (
    input  logic [63:0] i_in,
    output logic [32:0] o_out
);
    logic [31:0] w_a;
    logic [31:0] w_b;
    logic [31:0] w_g [6];
    logic [31:0] w_p [6];
    logic [31:0] w_sum;

    // Pins are MSB-first; prefix tree pairs each bit with the top of the lower half-block.
    always_comb begin
        int unsigned j;
        j = 0;
        w_a   = '0;
        w_b   = '0;
        w_sum = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            w_a[i] = i_in[31 - i];
            w_b[i] = i_in[63 - i];
        end
        w_g[0] = w_a & w_b;
        w_p[0] = w_a ^ w_b;
        for (int unsigned l = 0; l < 5; l++) begin
            w_g[l + 1] = w_g[l];
            w_p[l + 1] = w_p[l];
            for (int unsigned i = 0; i < 32; i++) begin
                if (((i >> l) & 1) == 1) begin
                    j = ((i >> l) << l) - 1;
                    w_g[l + 1][i] = w_g[l][i] | (w_p[l][i] & w_g[l][j]);
                    w_p[l + 1][i] = w_p[l][i] & w_p[l][j];
                end
            end
        end
        w_sum[0] = w_p[0][0];
        for (int unsigned i = 1; i < 32; i++) begin
            w_sum[i] = w_p[0][i] ^ w_g[5][i - 1];
        end
        o_out[0] = w_g[5][31];
        for (int unsigned i = 0; i < 32; i++) begin
            o_out[32 - i] = w_sum[i];
        end
    end
endmodule

module lf32_add_arbiter #(
    parameter  int unsigned NREQ = 4,
    parameter  int unsigned TAGW = 4,
    localparam int unsigned IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*32-1:0]   req_a,
    input  logic [NREQ*32-1:0]   req_b,
    input  logic [NREQ*TAGW-1:0] req_tag,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [31:0]          rsp_sum,
    output logic                 rsp_cout,
    output logic [IDW-1:0]       rsp_id,
    output logic [TAGW-1:0]      rsp_tag
);
    logic [IDW-1:0]  r_ptr;
    logic            r_s1_v;
    logic [31:0]     r_s1_a;
    logic [31:0]     r_s1_b;
    logic [IDW-1:0]  r_s1_id;
    logic [TAGW-1:0] r_s1_tag;
    logic            r_rsp_valid;
    logic [31:0]     r_rsp_sum;
    logic            r_rsp_cout;
    logic [IDW-1:0]  r_rsp_id;
    logic [TAGW-1:0] r_rsp_tag;

    logic            w_s2_load;
    logic            w_s1_free;
    logic            w_any;
    logic [IDW-1:0]  w_win;
    logic            w_accept;
    logic [NREQ-1:0] w_req_ready;
    logic [63:0]     w_lf_in;
    logic [32:0]     w_lf_out;
    logic [31:0]     w_sum;

    assign w_s2_load = r_s1_v & (~r_rsp_valid | rsp_ready);
    assign w_s1_free = ~r_s1_v | w_s2_load;
    assign w_accept  = w_s1_free & w_any & ~rst;

    always_comb begin
        int unsigned idx;
        idx   = 0;
        w_any = 1'b0;
        w_win = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = 32'(r_ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!w_any && req_valid[IDW'(idx)]) begin
                w_any = 1'b1;
                w_win = IDW'(idx);
            end
        end
    end

    always_comb begin
        w_req_ready = '0;
        if (w_accept) begin
            w_req_ready[w_win] = 1'b1;
        end
    end

    always_comb begin
        w_lf_in = '0;
        w_sum   = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            w_lf_in[i]      = r_s1_a[31 - i];
            w_lf_in[32 + i] = r_s1_b[31 - i];
            w_sum[i]        = w_lf_out[32 - i];
        end
    end

    lf32 u_lf32 (
        .i_in  (w_lf_in),
        .o_out (w_lf_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr       <= '0;
            r_s1_v      <= 1'b0;
            r_s1_a      <= '0;
            r_s1_b      <= '0;
            r_s1_id     <= '0;
            r_s1_tag    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_sum   <= '0;
            r_rsp_cout  <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_tag   <= '0;
        end else begin
            if (w_accept) begin
                r_s1_v   <= 1'b1;
                r_s1_a   <= req_a[32*w_win +: 32];
                r_s1_b   <= req_b[32*w_win +: 32];
                r_s1_tag <= req_tag[TAGW*w_win +: TAGW];
                r_s1_id  <= w_win;
                r_ptr    <= (32'(w_win) == NREQ - 1) ? '0 : w_win + 1'b1;
            end else if (w_s2_load) begin
                r_s1_v <= 1'b0;
            end
            if (w_s2_load) begin
                r_rsp_valid <= 1'b1;
                r_rsp_sum   <= w_sum;
                r_rsp_cout  <= w_lf_out[0];
                r_rsp_id    <= r_s1_id;
                r_rsp_tag   <= r_s1_tag;
            end else if (r_rsp_valid && rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign req_ready = w_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_sum   = r_rsp_sum;
    assign rsp_cout  = r_rsp_cout;
    assign rsp_id    = r_rsp_id;
    assign rsp_tag   = r_rsp_tag;
endmodule

// File: tb/tb_lf32_add_arbiter.sv
// Directed and random bench for lf32_add_arbiter against a queue-based model
// of grants and in-flight results.

module tb_lf32_add_arbiter;
    localparam int unsigned NREQ = 4;
    localparam int unsigned TAGW = 4;
    localparam int unsigned IDW  = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*32-1:0]   req_a;
    logic [NREQ*32-1:0]   req_b;
    logic [NREQ*TAGW-1:0] req_tag;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [31:0]          rsp_sum;
    logic                 rsp_cout;
    logic [IDW-1:0]       rsp_id;
    logic [TAGW-1:0]      rsp_tag;

    lf32_add_arbiter #(.NREQ(NREQ), .TAGW(TAGW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_tag   (req_tag),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_id    (rsp_id),
        .rsp_tag   (rsp_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]     sum;
        logic            cout;
        int unsigned     id;
        logic [TAGW-1:0] tag;
        bit              in_s2;
    } item_t;

    item_t                q[$];
    int unsigned          m_ptr = 0;
    bit                   m_known = 0;
    int                   n_chk = 0;
    int                   n_err = 0;
    int                   n_acc = 0;
    int                   n_obs_rsp = 0;
    logic [NREQ-1:0]      obs_rdy;
    int unsigned          last_grant = 0;
    bit                   last_acc = 0;
    logic [NREQ-1:0]      hold_mask = '0;
    logic [NREQ*32-1:0]   prev_a;
    logic [NREQ*32-1:0]   prev_b;
    logic [NREQ*TAGW-1:0] prev_t;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rnd32();
        case ($urandom % 8)
            0:       return 32'hFFFF_FFFF;
            1:       return 32'h0000_0000;
            2:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic set_req(input int unsigned i, input logic [31:0] a, input logic [31:0] b,
                           input logic [TAGW-1:0] t);
        req_a[32*i +: 32]     = a;
        req_b[32*i +: 32]     = b;
        req_tag[TAGW*i +: TAGW] = t;
        req_valid[i]          = 1'b1;
    endtask

    task automatic rnd_req(input int unsigned i);
        set_req(i, rnd32(), rnd32(), TAGW'($urandom));
    endtask

    // One clock: predict grant and output from the model, compare, then advance the model.
    task automatic cycle();
        logic [NREQ-1:0] exp_rdy;
        bit              valid_m, s1_full, s2_load, free, any;
        int unsigned     win, j;
        item_t           it, tmp;
        logic [32:0]     full;
        @(negedge clk);
        for (int unsigned i = 0; i < NREQ; i++) begin
            assert (!hold_mask[i] || (req_valid[i] && req_a[32*i +: 32] == prev_a[32*i +: 32] &&
                    req_b[32*i +: 32] == prev_b[32*i +: 32] &&
                    req_tag[TAGW*i +: TAGW] == prev_t[TAGW*i +: TAGW]))
            else $fatal(1, "FAIL req_hold requester %0d changed before accept", i);
        end
        valid_m = (q.size() > 0) && q[0].in_s2;
        s1_full = (q.size() > 0) && !q[q.size()-1].in_s2;
        s2_load = s1_full && (!valid_m || rsp_ready);
        free    = !s1_full || s2_load;
        any = 0;
        win = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            j = (m_ptr + k) % NREQ;
            if (!any && req_valid[j]) begin
                any = 1;
                win = j;
            end
        end
        exp_rdy = '0;
        if (free && any && !rst) exp_rdy[win] = 1'b1;
        obs_rdy = req_ready;
        chk("req_ready", obs_rdy, exp_rdy);
        if (m_known) begin
            chk("rsp_valid", rsp_valid, valid_m);
            if (valid_m) begin
                chk("rsp_sum", rsp_sum, q[0].sum);
                chk("rsp_cout", rsp_cout, q[0].cout);
                chk("rsp_id", rsp_id, q[0].id);
                chk("rsp_tag", rsp_tag, q[0].tag);
            end
            if (rsp_valid === 1'b1 && rsp_ready && !rst) n_obs_rsp++;
        end
        full   = {1'b0, req_a[32*win +: 32]} + {1'b0, req_b[32*win +: 32]};
        it.sum   = full[31:0];
        it.cout  = full[32];
        it.id    = win;
        it.tag   = req_tag[TAGW*win +: TAGW];
        it.in_s2 = 0;
        hold_mask = rst ? '0 : (req_valid & ~exp_rdy);
        prev_a = req_a;
        prev_b = req_b;
        prev_t = req_tag;
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_ptr    = 0;
            m_known  = 1;
            last_acc = 0;
        end else begin
            if (valid_m && rsp_ready) void'(q.pop_front());
            if (s2_load) begin
                tmp = q.pop_back();
                tmp.in_s2 = 1;
                q.push_back(tmp);
            end
            last_acc = (exp_rdy != '0);
            if (last_acc) begin
                q.push_back(it);
                m_ptr      = (win + 1) % NREQ;
                last_grant = win;
                n_acc++;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    task automatic chk_zero_outputs(input string pfx);
        chk({pfx, "_valid0"}, rsp_valid, 0);
        chk({pfx, "_sum0"}, rsp_sum, 0);
        chk({pfx, "_cout0"}, rsp_cout, 0);
        chk({pfx, "_id0"}, rsp_id, 0);
        chk({pfx, "_tag0"}, rsp_tag, 0);
    endtask

    initial begin
        int acc, obs0, acc0;
        rst       = 1'b1;
        rsp_ready = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_tag   = '0;
        cycle();
        cycle();
        rst = 1'b0;
        chk_zero_outputs("reset");

        // single request, two-cycle latency
        set_req(0, 32'h5, 32'h3, 4'd7);
        cycle();
        chk("t1_grant", obs_rdy, 4'b0001);
        chk("t1_not_yet", rsp_valid, 0);
        req_valid[0] = 1'b0;
        cycle();
        chk("t1_valid", rsp_valid, 1);
        chk("t1_sum", rsp_sum, 32'h8);
        chk("t1_cout", rsp_cout, 0);
        chk("t1_id", rsp_id, 0);
        chk("t1_tag", rsp_tag, 7);
        cycle();

        // overflow wrap
        set_req(2, 32'hFFFF_FFFF, 32'h1, 4'd3);
        cycle();
        chk("t2_grant_a", obs_rdy, 4'b0100);
        set_req(2, 32'h8000_0000, 32'h8000_0000, 4'd9);
        cycle();
        chk("t2_grant_b", obs_rdy, 4'b0100);
        chk("t2_sum_a", rsp_sum, 0);
        chk("t2_cout_a", rsp_cout, 1);
        chk("t2_id_a", rsp_id, 2);
        req_valid[2] = 1'b0;
        cycle();
        chk("t2_sum_b", rsp_sum, 0);
        chk("t2_cout_b", rsp_cout, 1);
        chk("t2_tag_b", rsp_tag, 9);
        cycle();

        // all requesters continuously valid
        do_reset();
        for (int unsigned i = 0; i < NREQ; i++) rnd_req(i);
        for (int unsigned k = 0; k < 12; k++) begin
            cycle();
            chk("t3_grant", obs_rdy, 4'b0001 << (k % 4));
            if (k >= 1) begin
                chk("t3_rsp_valid", rsp_valid, 1);
                chk("t3_rsp_id", rsp_id, (k - 1) % 4);
            end
            rnd_req(last_grant);
        end

        // backpressure
        do_reset();
        rsp_ready = 1'b0;
        acc  = 0;
        obs0 = n_obs_rsp;
        for (int k = 0; k < 5; k++) begin
            cycle();
            if (obs_rdy != '0) begin
                acc++;
                req_valid[last_grant] = 1'b0;
            end
        end
        chk("t4_accepts", acc, 2);
        chk("t4_blocked", obs_rdy, 0);
        rsp_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cycle();
            if (last_acc) req_valid[last_grant] = 1'b0;
        end
        chk("t4_drained", n_obs_rsp - obs0, 4);
        chk("t4_idle", rsp_valid, 0);

        // pointer wrap
        do_reset();
        set_req(3, 32'h1234_5678, 32'h1111_1111, 4'd1);
        cycle();
        chk("t5_grant3", obs_rdy, 4'b1000);
        rnd_req(3);
        rnd_req(1);
        cycle();
        chk("t5_grant1", obs_rdy, 4'b0010);
        req_valid[1] = 1'b0;
        cycle();
        chk("t5_grant3b", obs_rdy, 4'b1000);
        req_valid[3] = 1'b0;
        repeat (3) cycle();

        // reset with both stages full
        rsp_ready = 1'b0;
        rnd_req(0);
        cycle();
        rnd_req(0);
        cycle();
        chk("t6_full", rsp_valid, 1);
        rnd_req(0);
        rst = 1'b1;
        cycle();
        chk("t6_rdy_in_rst", obs_rdy, 0);
        rst = 1'b0;
        chk_zero_outputs("t6");
        req_valid = '0;
        rsp_ready = 1'b1;
        rnd_req(1);
        rnd_req(3);
        cycle();
        chk("t6_grant1", obs_rdy, 4'b0010);
        req_valid[1] = 1'b0;
        cycle();
        chk("t6_lat", rsp_valid, 1);
        chk("t6_id1", rsp_id, 1);
        req_valid[3] = 1'b0;
        cycle();
        chk("t6_id3", rsp_id, 3);
        cycle();

        // random regression
        do_reset();
        obs0 = n_obs_rsp;
        acc0 = n_acc;
        for (int n = 0; n < 10000; n++) begin
            rsp_ready = ($urandom % 4) != 0;
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && ($urandom % 2) == 0) rnd_req(i);
            end
            cycle();
            if (last_acc) begin
                if ($urandom % 2) req_valid[last_grant] = 1'b0;
                else rnd_req(last_grant);
            end
        end
        rsp_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            cycle();
            if (last_acc) req_valid[last_grant] = 1'b0;
        end
        chk("rand_all_answered", n_obs_rsp - obs0, n_acc - acc0);
        chk("rand_idle", rsp_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/lf32_add_arbiter.md
Name: lf32_add_arbiter

Overview:
- Shares one lf32 Ladner-Fischer 32-bit adder instance among NREQ requesters.
- Each requester presents an operand pair and a tag over valid/ready. A round-robin arbiter selects one request per cycle into an operand register.
- The adder evaluates combinationally from that register. A result register returns sum, carry-out, requester id and tag over a valid/ready response port with backpressure.
- Sits between the datapath clients and the shared adder, replacing per-client adders.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TAGW, 4, width of the opaque per-request tag returned with the result.
- IDW, $clog2(NREQ), width of the requester id; derived, not overridable.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req_valid  input  NREQ  per-requester request valid
- req_ready  output  NREQ  per-requester accept; one-hot or zero
- req_a  input  NREQ*32  operand A, requester i at bits [32i+31:32i]
- req_b  input  NREQ*32  operand B, same packing
- req_tag  input  NREQ*TAGW  tag, requester i at bits [TAGW*i+TAGW-1:TAGW*i]
- rsp_valid  output  1  result valid
- rsp_ready  input  1  consumer accepts result
- rsp_sum  output  32  (a+b) mod 2^32
- rsp_cout  output  1  carry out of bit 31
- rsp_id  output  IDW  index of the requester that issued the result
- rsp_tag  output  TAGW  tag of that request

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous and active-high.
- Adder hookup:
  - lf32 in0..in31 = s1_a[31..0], MSB first (in0 = a[31], in31 = a[0]).
  - in32..in63 = s1_b[31..0], same order.
  - out0 = carry out; out1..out32 = sum[31..0], MSB first.
  - There is no carry-in.
- Stage S1 (operand register): s1_v, s1_a, s1_b, s1_id, s1_tag.
- Stage S2 (result register): rsp_valid, rsp_sum, rsp_cout, rsp_id, rsp_tag.
- Advance rules:
  - s2_load = s1_v & (~rsp_valid | rsp_ready).
  - s1_free = ~s1_v | s2_load.
- Arbitration (combinational):
  - Scan from priority pointer ptr upward, modulo NREQ.
  - The first i with req_valid[i] is the winner.
  - req_ready[i] = s1_free & winner==i. All req_ready are 0 when s1_free=0.
- Accept: on a cycle with req_valid[i] & req_ready[i], S1 captures requester i's a, b, tag and id=i; s1_v=1; ptr <= (i+1) mod NREQ.
- ptr holds when there is no accept.
- S1 drain: if S1 drains (s2_load) with no new accept, s1_v <= 0.
- S2 load: on s2_load, S2 captures the adder outputs plus s1_id/s1_tag; rsp_valid=1.
- S2 drain: if rsp_valid & rsp_ready & ~s2_load, rsp_valid <= 0.
- Latency and throughput:
  - Accept at edge t gives rsp_valid high after edge t+1 (2 cycles) when unstalled.
  - Sustained throughput is 1 result/cycle with rsp_ready held high.
- Stall: while rsp_valid & ~rsp_ready, every rsp_* output holds stable. S1 holds its content; if S1 is full, all req_ready=0.
- Capacity: at most 2 requests are in flight. Results return in accept order.
- Fairness: a continuously asserted request is granted within NREQ accepts.
- Requester obligations: req_valid must not depend combinationally on req_ready. Once raised, a requester holds req_valid and its operands until accepted (checked by assertion in the bench, not enforced in RTL).
- Arithmetic wrap: sum is taken mod 2^32 and cout reports the overflow, e.g. FFFFFFFF+1 gives sum 0, cout 1.
- Reset: ptr=0, s1_v=0, rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_id=0, rsp_tag=0. S1 data registers are cleared to 0.
- Reset mid-operation: in-flight requests are discarded without response. req_ready is 0 during the rst cycle.
- Simultaneous requests: at most one grant per cycle.
- S2 drain and reload in the same cycle: S2 drains and reloads with no bubble.

Test Plan:
- Single request, rsp_ready=1, req0 a=0000_0005 b=0000_0003 tag=7 → req_ready[0] that cycle; 2 cycles later rsp_valid=1, sum=0000_0008, cout=0, id=0, tag=7.
- Overflow, req2 a=FFFF_FFFF b=0000_0001 → sum=0000_0000, cout=1, id=2. Also a=8000_0000 b=8000_0000 → sum=0, cout=1.
- All 4 requesters valid continuously, rsp_ready=1, from reset → grant order 0,1,2,3,0,1,…; one rsp per cycle, ids in the same order; each sum matches the reference model.
- Backpressure: rsp_ready=0 for 5 cycles with requests pending → exactly 2 accepts, then req_ready=0; rsp_* stable throughout. On rsp_ready=1, results drain in order with no loss or duplication.
- ptr behaviour with only req3 valid, then req1 and req3 together → req3 granted, then req1 (ptr wrapped to 0 and scanned upward), then req3.
- Reset asserted with S1 and S2 full → the next cycle rsp_valid=0, all outputs 0; the first post-reset request is granted per ptr=0 with latency 2.
- Random regression: 10k random operands, valids and rsp_ready → every accepted request gets exactly one response with the correct sum, cout, id and tag.
